// File: rtl/kbd_scancode_decoder_pkg.sv
// rtl/kbd_scancode_decoder_pkg.sv - scan-code constants and FSM states for the keyboard decoder
package kbd_scancode_decoder_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_KP_DIV = 8'h4A;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BREAK,
    ST_EXT,
    ST_EXT_BREAK
  } kbd_state_t;

  // Keyboard status/ack bytes that carry no key information.
  function automatic logic is_status_code(input logic [7:0] code);
    return (code == 8'hAA) || (code == 8'hFA) || (code == 8'hFE) ||
           (code == 8'hEE) || (code == 8'h00) || (code == 8'hFF);
  endfunction

endpackage

// File: rtl/kbd_scan2ascii.sv
// rtl/kbd_scan2ascii.sv - combinational US-QWERTY set-2 scan code to ASCII lookup
module kbd_scan2ascii (
  input  logic [7:0] code,
  input  logic       shift,
  input  logic       caps,
  input  logic       ctrl,
  output logic [7:0] ascii
);

  logic [7:0] letter;
  logic [7:0] other;

  always_comb begin
    letter = 8'h00;
    case (code)
      8'h1C: letter = "a";  8'h32: letter = "b";  8'h21: letter = "c";
      8'h23: letter = "d";  8'h24: letter = "e";  8'h2B: letter = "f";
      8'h34: letter = "g";  8'h33: letter = "h";  8'h43: letter = "i";
      8'h3B: letter = "j";  8'h42: letter = "k";  8'h4B: letter = "l";
      8'h3A: letter = "m";  8'h31: letter = "n";  8'h44: letter = "o";
      8'h4D: letter = "p";  8'h15: letter = "q";  8'h2D: letter = "r";
      8'h1B: letter = "s";  8'h2C: letter = "t";  8'h3C: letter = "u";
      8'h2A: letter = "v";  8'h1D: letter = "w";  8'h22: letter = "x";
      8'h35: letter = "y";  8'h1A: letter = "z";
      default: letter = 8'h00;
    endcase
  end

  always_comb begin
    other = 8'h00;
    case (code)
      8'h45: other = shift ? ")"  : "0";
      8'h16: other = shift ? "!"  : "1";
      8'h1E: other = shift ? "@"  : "2";
      8'h26: other = shift ? "#"  : "3";
      8'h25: other = shift ? "$"  : "4";
      8'h2E: other = shift ? "%"  : "5";
      8'h36: other = shift ? "^"  : "6";
      8'h3D: other = shift ? "&"  : "7";
      8'h3E: other = shift ? "*"  : "8";
      8'h46: other = shift ? "("  : "9";
      8'h0E: other = shift ? "~"  : 8'h60;
      8'h4E: other = shift ? "_"  : "-";
      8'h55: other = shift ? "+"  : "=";
      8'h54: other = shift ? "{"  : "[";
      8'h5B: other = shift ? "}"  : "]";
      8'h5D: other = shift ? "|"  : "\\";
      8'h4C: other = shift ? ":"  : ";";
      8'h52: other = shift ? "\"" : "'";
      8'h41: other = shift ? "<"  : ",";
      8'h49: other = shift ? ">"  : ".";
      8'h4A: other = shift ? "?"  : "/";
      8'h29: other = 8'h20;
      8'h5A: other = 8'h0D;
      8'h66: other = 8'h08;
      8'h0D: other = 8'h09;
      8'h76: other = 8'h1B;
      default: other = 8'h00;
    endcase
  end

  // Ctrl wins over shift/caps for letters; clearing bit 5 gives uppercase.
  always_comb begin
    ascii = other;
    if (letter != 8'h00) begin
      if (ctrl)              ascii = letter & 8'h1F;
      else if (shift ^ caps) ascii = letter & 8'hDF;
      else                   ascii = letter;
    end
  end

endmodule

// File: rtl/kbd_scancode_decoder.sv
// rtl/kbd_scancode_decoder.sv - PS/2 set-2 scan-code stream to ASCII character stream
module kbd_scancode_decoder
  import kbd_scancode_decoder_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = 8,
  parameter bit CAPS_RESET      = 1'b0
) (
  input  logic                       axis_aclk_i,
  input  logic                       axis_aresetn_i,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata_i,
  input  logic                       s_axis_tvalid_i,
  output logic                       s_axis_tready_o,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata_o,
  output logic                       m_axis_tvalid_o,
  input  logic                       m_axis_tready_i,
  output logic [2:0]                 modifiers_o
);

  kbd_state_t state_q, state_d;
  logic       lshift_q, lshift_d, rshift_q, rshift_d;
  logic       lctrl_q, lctrl_d, rctrl_q, rctrl_d;
  logic       caps_q, caps_d;
  logic       valid_q, valid_d;
  logic [7:0] data_q, data_d;
  logic [7:0] code;
  logic [7:0] ascii;
  logic       accept;
  logic       shift;
  logic       ctrl;

  assign code   = s_axis_tdata_i[7:0];
  assign shift  = lshift_q | rshift_q;
  assign ctrl   = lctrl_q | rctrl_q;
  assign accept = s_axis_tvalid_i && !valid_q;

  assign s_axis_tready_o = !valid_q;
  assign m_axis_tvalid_o = valid_q;
  assign m_axis_tdata_o  = AXIS_DATA_WIDTH'(data_q);
  assign modifiers_o     = {ctrl, caps_q, shift};

  kbd_scan2ascii u_lookup (
    .code  (code),
    .shift (shift),
    .caps  (caps_q),
    .ctrl  (ctrl),
    .ascii (ascii)
  );

  always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
    if (!axis_aresetn_i) begin
      state_q  <= ST_IDLE;
      lshift_q <= 1'b0;
      rshift_q <= 1'b0;
      lctrl_q  <= 1'b0;
      rctrl_q  <= 1'b0;
      caps_q   <= CAPS_RESET;
      valid_q  <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      lshift_q <= lshift_d;
      rshift_q <= rshift_d;
      lctrl_q  <= lctrl_d;
      rctrl_q  <= rctrl_d;
      caps_q   <= caps_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
    end
  end

  // Bytes are only accepted while the output register is empty, so an accept
  // never collides with a pending character.
  always_comb begin
    state_d  = state_q;
    lshift_d = lshift_q;
    rshift_d = rshift_q;
    lctrl_d  = lctrl_q;
    rctrl_d  = rctrl_q;
    caps_d   = caps_q;
    valid_d  = valid_q && !m_axis_tready_i;
    data_d   = data_q;
    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (code == SC_EXT)              state_d  = ST_EXT;
          else if (code == SC_BREAK)       state_d  = ST_BREAK;
          else if (code == SC_LSHIFT)      lshift_d = 1'b1;
          else if (code == SC_RSHIFT)      rshift_d = 1'b1;
          else if (code == SC_CTRL)        lctrl_d  = 1'b1;
          else if (code == SC_CAPS)        caps_d   = !caps_q;
          else if (!is_status_code(code) && ascii != 8'h00) begin
            valid_d = 1'b1;
            data_d  = ascii;
          end
        end
        ST_BREAK: begin
          if (code == SC_LSHIFT) lshift_d = 1'b0;
          if (code == SC_RSHIFT) rshift_d = 1'b0;
          if (code == SC_CTRL)   lctrl_d  = 1'b0;
          state_d = ST_IDLE;
        end
        ST_EXT: begin
          state_d = ST_IDLE;
          if (code == SC_BREAK)    state_d = ST_EXT_BREAK;
          else if (code == SC_EXT) state_d = ST_EXT;
          else if (code == SC_CTRL) rctrl_d = 1'b1;
          else if (code == SC_ENTER) begin
            valid_d = 1'b1;
            data_d  = 8'h0D;
          end else if (code == SC_KP_DIV) begin
            valid_d = 1'b1;
            data_d  = "/";
          end
        end
        ST_EXT_BREAK: begin
          if (code == SC_CTRL) rctrl_d = 1'b0;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kbd_scancode_decoder.sv
// tb/tb_kbd_scancode_decoder.sv - self-checking bench for kbd_scancode_decoder
module tb_kbd_scancode_decoder;

  logic       clk;
  logic       resetn;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tready;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready;
  logic [2:0] mods;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] code;
    logic       emit;
    logic [7:0] data;
    logic [2:0] mods;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] got_q[$];

  kbd_scancode_decoder #(.AXIS_DATA_WIDTH(8), .CAPS_RESET(1'b0)) dut (
    .axis_aclk_i     (clk),
    .axis_aresetn_i  (resetn),
    .s_axis_tdata_i  (s_tdata),
    .s_axis_tvalid_i (s_tvalid),
    .s_axis_tready_o (s_tready),
    .m_axis_tdata_o  (m_tdata),
    .m_axis_tvalid_o (m_tvalid),
    .m_axis_tready_i (m_tready),
    .modifiers_o     (mods)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (m_tvalid && m_tready) got_q.push_back(m_tdata);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic send(input logic [7:0] c);
    int n;
    n = 0;
    s_tdata  = c;
    s_tvalid = 1'b1;
    while (!s_tready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!s_tready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: code %0h never accepted", c);
      s_tvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic add(input logic [7:0] c, input logic e, input logic [7:0] d, input logic [2:0] m);
    vecs.push_back(vec_t'{code: c, emit: e, data: d, mods: m});
  endtask

  initial begin
    // 1: plain make
    add(8'h1C, 1, 8'h61, 3'b000);
    // 2: shift make/break
    add(8'h12, 0, 8'h00, 3'b001); add(8'h1C, 1, 8'h41, 3'b001);
    add(8'hF0, 0, 8'h00, 3'b001); add(8'h12, 0, 8'h00, 3'b000);
    add(8'h1C, 1, 8'h61, 3'b000);
    // 3: caps lock with and without shift
    add(8'h58, 0, 8'h00, 3'b010); add(8'h1C, 1, 8'h41, 3'b010);
    add(8'h12, 0, 8'h00, 3'b011); add(8'h1C, 1, 8'h61, 3'b011);
    add(8'h16, 1, 8'h21, 3'b011); add(8'hF0, 0, 8'h00, 3'b011);
    add(8'h12, 0, 8'h00, 3'b010); add(8'h58, 0, 8'h00, 3'b000);
    // 4: extended keys
    add(8'hE0, 0, 8'h00, 3'b000); add(8'h5A, 1, 8'h0D, 3'b000);
    add(8'hE0, 0, 8'h00, 3'b000); add(8'h75, 0, 8'h00, 3'b000);
    add(8'hE0, 0, 8'h00, 3'b000); add(8'hF0, 0, 8'h00, 3'b000);
    add(8'h75, 0, 8'h00, 3'b000); add(8'h1C, 1, 8'h61, 3'b000);
    // 6a: left ctrl
    add(8'h14, 0, 8'h00, 3'b100); add(8'h21, 1, 8'h03, 3'b100);
    add(8'hF0, 0, 8'h00, 3'b100); add(8'h14, 0, 8'h00, 3'b000);
    add(8'h21, 1, 8'h63, 3'b000);
    // right ctrl; ctrl leaves digits alone
    add(8'hE0, 0, 8'h00, 3'b000); add(8'h14, 0, 8'h00, 3'b100);
    add(8'h1C, 1, 8'h01, 3'b100); add(8'h16, 1, 8'h31, 3'b100);
    add(8'hE0, 0, 8'h00, 3'b100); add(8'hF0, 0, 8'h00, 3'b100);
    add(8'h14, 0, 8'h00, 3'b000);
    // keypad slash vs main slash, shifted punctuation
    add(8'hE0, 0, 8'h00, 3'b000); add(8'h4A, 1, 8'h2F, 3'b000);
    add(8'h12, 0, 8'h00, 3'b001); add(8'h4A, 1, 8'h3F, 3'b001);
    add(8'h52, 1, 8'h22, 3'b001); add(8'hF0, 0, 8'h00, 3'b001);
    add(8'h12, 0, 8'h00, 3'b000); add(8'h52, 1, 8'h27, 3'b000);
    // control keys, status byte, unmapped code
    add(8'h29, 1, 8'h20, 3'b000); add(8'h66, 1, 8'h08, 3'b000);
    add(8'hAA, 0, 8'h00, 3'b000); add(8'h77, 0, 8'h00, 3'b000);
    // typematic repeat, break consumes E0, E0 E0 stays extended, EXT ignores others
    add(8'h1C, 1, 8'h61, 3'b000); add(8'h1C, 1, 8'h61, 3'b000);
    add(8'hF0, 0, 8'h00, 3'b000); add(8'hE0, 0, 8'h00, 3'b000);
    add(8'h1C, 1, 8'h61, 3'b000); add(8'hE0, 0, 8'h00, 3'b000);
    add(8'hE0, 0, 8'h00, 3'b000); add(8'h5A, 1, 8'h0D, 3'b000);
    add(8'hE0, 0, 8'h00, 3'b000); add(8'h1C, 0, 8'h00, 3'b000);
    add(8'h1C, 1, 8'h61, 3'b000);

    resetn   = 1'b0;
    s_tdata  = 8'h00;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", m_tvalid, 0);
    chk("reset_data", m_tdata, 8'h00);
    chk("reset_tready", s_tready, 1);
    chk("reset_mods", mods, 3'b000);
    resetn = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      send(vecs[i].code);
      chk($sformatf("vec%0d_valid", i), m_tvalid, vecs[i].emit);
      if (vecs[i].emit) chk($sformatf("vec%0d_data", i), m_tdata, vecs[i].data);
      chk($sformatf("vec%0d_mods", i), mods, vecs[i].mods);
    end

    // 5: back-pressure holds the character and stalls input
    @(posedge clk); #1;
    got_q.delete();
    m_tready = 1'b0;
    send(8'h1C);
    chk("bp_valid", m_tvalid, 1);
    s_tdata  = 8'h32;
    s_tvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("bp_hold_data", m_tdata, 8'h61);
      chk("bp_hold_valid", m_tvalid, 1);
      chk("bp_stall_tready", s_tready, 0);
    end
    m_tready = 1'b1;
    @(posedge clk); #1;
    chk("bp_drain_valid", m_tvalid, 0);
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    chk("bp_second_data", m_tdata, 8'h62);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("bp_first", got_q[0], 8'h61);
      chk("bp_second", got_q[1], 8'h62);
    end

    // 6b: async reset drops a pending E0 and all modifiers
    send(8'h58);
    send(8'h12);
    send(8'hE0);
    chk("pre_reset_mods", mods, 3'b011);
    resetn = 1'b0;
    #2;
    chk("async_reset_mods", mods, 3'b000);
    chk("async_reset_valid", m_tvalid, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    send(8'h1C);
    chk("post_reset_valid", m_tvalid, 1);
    chk("post_reset_data", m_tdata, 8'h61);
    chk("post_reset_mods", mods, 3'b000);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
